// File: rtl/run_ctrl_pkg.sv
// rtl/run_ctrl_pkg.sv - shared state encoding for the CPU run controller
package run_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_RST_HOLD = 3'd1,
    ST_RUN      = 3'd2,
    ST_HALTED   = 3'd3,
    ST_TIMEOUT  = 3'd4
  } run_state_e;

endpackage

// File: rtl/halt_detect.sv
// rtl/halt_detect.sv - branch-to-self detector over retired PCs
module halt_detect
  import run_ctrl_pkg::*;
#(
  parameter int PC_W        = 32,
  parameter int HALT_REPEAT = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            retire,
  input  logic            enable,
  input  logic [PC_W-1:0] pc,
  output logic            halt
);

  localparam int RPT_W = $clog2(HALT_REPEAT + 1);

  logic [PC_W-1:0]  last_pc_q, last_pc_d;
  logic             valid_q, valid_d;
  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic             hit, same_pc;

  // valid_q keeps the first retirement after a clear from matching the reset PC
  always_comb begin
    hit       = retire & enable;
    same_pc   = valid_q & (pc == last_pc_q);
    halt      = hit & same_pc & (rpt_q == RPT_W'(HALT_REPEAT - 1));
    last_pc_d = last_pc_q;
    valid_d   = valid_q;
    rpt_d     = rpt_q;
    if (clear) begin
      last_pc_d = '0;
      valid_d   = 1'b0;
      rpt_d     = '0;
    end else if (hit) begin
      if (same_pc) begin
        rpt_d = rpt_q + 1'b1;
      end else begin
        last_pc_d = pc;
        valid_d   = 1'b1;
        rpt_d     = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_pc_q <= '0;
      valid_q   <= 1'b0;
      rpt_q     <= '0;
    end else begin
      last_pc_q <= last_pc_d;
      valid_q   <= valid_d;
      rpt_q     <= rpt_d;
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - CPU reset sequencing, clock gating, counters and halt/timeout FSM
module cpu_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int RESET_CYCLES = 4,
  parameter int CNT_W        = 32,
  parameter int MAX_CYCLES   = 10000,
  parameter int PC_W         = 32,
  parameter int HALT_REPEAT  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               step_mode,
  input  logic               step_req,
  input  logic               retire,
  input  logic [PC_W-1:0]    retire_pc,
  output logic               cpu_reset,
  output logic               cpu_clk_en,
  output logic [CNT_W-1:0]   cycle_count,
  output logic [CNT_W-1:0]   retire_count,
  output logic               done,
  output logic               timed_out,
  output logic [STATE_W-1:0] state
);

  localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  run_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic [CNT_W-1:0]  ret_q, ret_d;
  logic              done_q, timed_out_q;
  logic              run_en, start_go, halt;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    cyc_d      = cyc_q;
    ret_d      = ret_q;
    run_en     = (state_q == ST_RUN) & (~step_mode | step_req);
    cpu_clk_en = run_en | (state_q == ST_RST_HOLD);
    cpu_reset  = (state_q == ST_IDLE) | (state_q == ST_RST_HOLD);
    start_go   = start & ~abort &
                 ((state_q == ST_IDLE) | (state_q == ST_HALTED) | (state_q == ST_TIMEOUT));
    if (abort) begin
      state_d = ST_IDLE;
    end else if (start_go) begin
      state_d = ST_RST_HOLD;
      hold_d  = '0;
      cyc_d   = '0;
      ret_d   = '0;
    end else begin
      case (state_q)
        ST_RST_HOLD: begin
          if (hold_q == HOLD_W'(RESET_CYCLES - 1)) state_d = ST_RUN;
          else hold_d = hold_q + 1'b1;
        end
        ST_RUN: begin
          if (run_en) begin
            cyc_d = cyc_q + 1'b1;
            if (retire) ret_d = ret_q + 1'b1;
            // a halt on the last budgeted cycle is still reported as a halt
            if (halt) state_d = ST_HALTED;
            else if (cyc_q == CNT_W'(MAX_CYCLES - 1)) state_d = ST_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      cyc_q       <= '0;
      ret_q       <= '0;
      done_q      <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      cyc_q       <= cyc_d;
      ret_q       <= ret_d;
      done_q      <= (state_d == ST_HALTED);
      timed_out_q <= (state_d == ST_TIMEOUT);
    end
  end

  halt_detect #(
    .PC_W        (PC_W),
    .HALT_REPEAT (HALT_REPEAT)
  ) u_halt_detect (
    .clk    (clk),
    .reset  (reset),
    .clear  (start_go),
    .retire (retire),
    .enable (run_en & ~abort),
    .pc     (retire_pc),
    .halt   (halt)
  );

  assign cycle_count  = cyc_q;
  assign retire_count = ret_q;
  assign done         = done_q;
  assign timed_out    = timed_out_q;
  assign state        = state_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - scoreboard bench for cpu_run_ctrl
module tb_cpu_run_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, abort, step_mode, step_req, retire;
  logic [31:0] retire_pc;
  logic        cpu_reset, cpu_clk_en, done, timed_out;
  logic [31:0] cycle_count, retire_count;
  logic [2:0]  state;

  cpu_run_ctrl #(
    .RESET_CYCLES (4),
    .CNT_W        (32),
    .MAX_CYCLES   (20),
    .PC_W         (32),
    .HALT_REPEAT  (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .step_mode    (step_mode),
    .step_req     (step_req),
    .retire       (retire),
    .retire_pc    (retire_pc),
    .cpu_reset    (cpu_reset),
    .cpu_clk_en   (cpu_clk_en),
    .cycle_count  (cycle_count),
    .retire_count (retire_count),
    .done         (done),
    .timed_out    (timed_out),
    .state        (state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  st;
    logic        rst;
    logic        en;
    logic [31:0] cc;
    logic [31:0] rc;
    logic        dn;
    logic        to;
    int          cy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ev     = 0;

  function automatic void push(input logic [2:0] st, input logic rst, input logic en,
                               input int cc, input int rc, input logic dn, input logic to,
                               input int cy);
    exp_t e;
    e.st = st; e.rst = rst; e.en = en; e.cc = cc; e.rc = rc;
    e.dn = dn; e.to = to; e.cy = cy;
    exp_q.push_back(e);
  endfunction

  // monitor: every state change (and the first post-reset cycle) is a DUT output event
  logic [2:0] prev_st = 3'h7;
  always @(negedge clk) begin
    exp_t e;
    if (!reset && state !== prev_st) begin
      prev_st = state;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_state actual st=%0d required no event", state);
      end else begin
        e = exp_q.pop_front();
        if (state !== e.st || cpu_reset !== e.rst || cpu_clk_en !== e.en ||
            cycle_count !== e.cc || retire_count !== e.rc || done !== e.dn ||
            timed_out !== e.to || (e.cy >= 0 && cyc != e.cy)) begin
          errors++;
          $display("FAIL ev%0d actual st=%0d rst=%0b en=%0b cc=%0d rc=%0d done=%0b to=%0b cyc=%0d required st=%0d rst=%0b en=%0b cc=%0d rc=%0d done=%0b to=%0b cyc=%0d",
                   ev, state, cpu_reset, cpu_clk_en, cycle_count, retire_count, done, timed_out, cyc,
                   e.st, e.rst, e.en, e.cc, e.rc, e.dn, e.to, e.cy);
        end
      end
      ev++;
    end
  end

  task automatic drive(input logic s, input logic ab, input logic r,
                       input logic [31:0] pc, input logic sr);
    start = s; abort = ab; retire = r; retire_pc = pc; step_req = sr;
    @(posedge clk); #1;
  endtask

  int en_cnt;

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; step_mode = 1'b0;
    step_req = 1'b0; retire = 1'b0; retire_pc = '0;

    // reset, start at cycle 10, hold 11-14, RUN at 15, halt after PCs 0,4,8,8,8
    push(3'd0, 1, 0, 0, 0, 0, 0, -1);
    push(3'd1, 1, 1, 0, 0, 0, 0, 11);
    push(3'd2, 0, 1, 0, 0, 0, 0, 15);
    push(3'd3, 0, 0, 5, 5, 1, 0, 20);
    // timeout after 20 enabled cycles with no repeated PC
    push(3'd1, 1, 1, 0, 0, 0, 0, -1);
    push(3'd2, 0, 1, 0, 0, 0, 0, -1);
    push(3'd4, 0, 0, 20, 20, 0, 1, -1);
    // single-step run, then abort at cycle_count 7
    push(3'd1, 1, 1, 0, 0, 0, 0, -1);
    push(3'd2, 0, 0, 0, 0, 0, 0, -1);
    push(3'd0, 1, 0, 7, 7, 0, 0, -1);
    // restart; halt and timeout coincide on the 20th enabled cycle
    push(3'd1, 1, 1, 0, 0, 0, 0, -1);
    push(3'd2, 0, 1, 0, 0, 0, 0, -1);
    push(3'd3, 0, 0, 20, 3, 1, 0, -1);
    // abort from HALTED keeps counters
    push(3'd0, 1, 0, 20, 3, 0, 0, -1);

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    while (cyc < 10) drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    repeat (4) drive(0, 0, 0, 0, 0);
    drive(0, 0, 1, 32'h00, 0);
    drive(0, 0, 1, 32'h04, 0);
    drive(0, 0, 1, 32'h08, 0);
    drive(0, 0, 1, 32'h08, 0);
    drive(0, 0, 1, 32'h08, 0);
    repeat (2) drive(0, 0, 0, 0, 0);

    drive(1, 0, 0, 0, 0);
    repeat (4) drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 25; i++) drive(0, 0, 1, 32'h1000 + 4 * i, 0);
    repeat (2) drive(0, 0, 0, 0, 0);

    step_mode = 1'b1;
    drive(1, 0, 0, 0, 0);
    repeat (4) drive(0, 0, 0, 0, 0);
    en_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      start = 1'b0; abort = 1'b0; retire = 1'b1;
      retire_pc = 32'h100 + 4 * i;
      step_req = (i == 10 || i == 25 || i == 40);
      #1;
      if (cpu_clk_en) en_cnt++;
      @(posedge clk); #1;
    end
    checks++;
    if (en_cnt != 3) begin
      errors++;
      $display("FAIL step_enables actual %0d required 3", en_cnt);
    end
    for (int i = 0; i < 10; i++)
      drive(0, 0, 1, 32'h400 + 4 * i, (i == 2 || i == 4 || i == 6 || i == 8));
    drive(0, 1, 0, 0, 0);

    step_mode = 1'b0;
    drive(1, 0, 0, 0, 0);
    repeat (4) drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) drive(0, 0, (i >= 17), 32'h200, 0);
    repeat (2) drive(0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) drive(0, 0, 0, 0, 0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL events_pending actual %0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
